// File: rtl/pe_inst_issuer.sv
// pe_inst_issuer: issues a fixed command program to one PE controller's
// instruction port (SET, optional LOAD_WGHT, N x (LOAD_IFMAP, CONV), ACC),
// then waits for the PE to return to idle and pulses done.
module pe_inst_issuer #(
  parameter int unsigned N_PASS_BITWIDTH    = 4,
  parameter int unsigned CONV_INFO_BITWIDTH = 9
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [CONV_INFO_BITWIDTH-1:0] i_cfg_conv_info,
  input  logic [N_PASS_BITWIDTH-1:0]    i_cfg_npass,
  input  logic                          i_cfg_load_wght,
  output logic [2:0]                    o_opcode,
  output logic [CONV_INFO_BITWIDTH-1:0] o_conv_info,
  output logic                          o_inst_valid,
  input  logic                          i_inst_ready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [N_PASS_BITWIDTH-1:0]    o_pass_cnt
);

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_NOP        = 3'b000;
  localparam logic [OPC_W-1:0] OPC_SET        = 3'b001;
  localparam logic [OPC_W-1:0] OPC_LOAD_IFMAP = 3'b010;
  localparam logic [OPC_W-1:0] OPC_LOAD_WGHT  = 3'b011;
  localparam logic [OPC_W-1:0] OPC_CONV       = 3'b100;
  localparam logic [OPC_W-1:0] OPC_ACC        = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ISS_SET   = 4'd1,
    S_ISS_WGHT  = 4'd2,
    S_ISS_IFMAP = 4'd3,
    S_ISS_CONV  = 4'd4,
    S_ISS_ACC   = 4'd5,
    S_DRAIN_LO  = 4'd6,
    S_DRAIN_HI  = 4'd7,
    S_FIN       = 4'd8
  } state_t;

  state_t                          state_q, state_d;
  logic [OPC_W-1:0]                opcode_d;
  logic                            valid_d;
  logic                            busy_d;
  logic                            done_d;
  logic [N_PASS_BITWIDTH-1:0]      pass_d;
  logic [CONV_INFO_BITWIDTH-1:0]   conv_d;
  logic                            load_wght_q, load_wght_d;
  // Index of the final pass (npass_eff - 1); a zero npass still runs one pass.
  logic [N_PASS_BITWIDTH-1:0]      last_pass_q, last_pass_d;
  logic                            hs_c;

  assign hs_c = o_inst_valid & i_inst_ready;

  // State register and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      o_opcode     <= OPC_NOP;
      o_inst_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_pass_cnt   <= '0;
      o_conv_info  <= '0;
      load_wght_q  <= 1'b0;
      last_pass_q  <= '0;
    end else begin
      state_q      <= state_d;
      o_opcode     <= opcode_d;
      o_inst_valid <= valid_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_pass_cnt   <= pass_d;
      o_conv_info  <= conv_d;
      load_wght_q  <= load_wght_d;
      last_pass_q  <= last_pass_d;
    end
  end

  // Next-state and next-output decode; each issue state raises valid for its
  // opcode, holds it until the handshake, then drops valid for one cycle.
  always_comb begin
    state_d     = state_q;
    opcode_d    = o_opcode;
    valid_d     = o_inst_valid;
    busy_d      = o_busy;
    done_d      = 1'b0;
    pass_d      = o_pass_cnt;
    conv_d      = o_conv_info;
    load_wght_d = load_wght_q;
    last_pass_d = last_pass_q;

    case (state_q)
      S_IDLE: begin
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        opcode_d = OPC_NOP;
        if (i_start) begin
          conv_d      = i_cfg_conv_info;
          load_wght_d = i_cfg_load_wght;
          last_pass_d = (i_cfg_npass == '0) ? '0
                        : N_PASS_BITWIDTH'(i_cfg_npass - N_PASS_BITWIDTH'(1));
          pass_d      = '0;
          busy_d      = 1'b1;
          state_d     = S_ISS_SET;
        end
      end

      S_ISS_SET: begin
        opcode_d = OPC_SET;
        if (hs_c) begin
          valid_d = 1'b0;
          state_d = load_wght_q ? S_ISS_WGHT : S_ISS_IFMAP;
        end else begin
          valid_d = 1'b1;
        end
      end

      S_ISS_WGHT: begin
        opcode_d = OPC_LOAD_WGHT;
        if (hs_c) begin
          valid_d = 1'b0;
          state_d = S_ISS_IFMAP;
        end else begin
          valid_d = 1'b1;
        end
      end

      S_ISS_IFMAP: begin
        opcode_d = OPC_LOAD_IFMAP;
        if (hs_c) begin
          valid_d = 1'b0;
          state_d = S_ISS_CONV;
        end else begin
          valid_d = 1'b1;
        end
      end

      S_ISS_CONV: begin
        opcode_d = OPC_CONV;
        if (hs_c) begin
          valid_d = 1'b0;
          if (o_pass_cnt == last_pass_q) begin
            state_d = S_ISS_ACC;
          end else begin
            pass_d  = N_PASS_BITWIDTH'(o_pass_cnt + N_PASS_BITWIDTH'(1));
            state_d = S_ISS_IFMAP;
          end
        end else begin
          valid_d = 1'b1;
        end
      end

      S_ISS_ACC: begin
        opcode_d = OPC_ACC;
        if (hs_c) begin
          valid_d = 1'b0;
          state_d = S_DRAIN_LO;
        end else begin
          valid_d = 1'b1;
        end
      end

      // Wait for the PE to leave idle after accepting ACC
      S_DRAIN_LO: begin
        valid_d  = 1'b0;
        opcode_d = OPC_NOP;
        if (!i_inst_ready) begin
          state_d = S_DRAIN_HI;
        end
      end

      // Wait for the PE to come back to idle, then signal completion
      S_DRAIN_HI: begin
        valid_d  = 1'b0;
        opcode_d = OPC_NOP;
        if (i_inst_ready) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        opcode_d = OPC_NOP;
        state_d  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_inst_issuer.sv
// Testbench for pe_inst_issuer: a PE model drives ready, a reference model
// expands each accepted start into its command list, and a monitor checks
// every handshake against that list.
module tb_pe_inst_issuer;

  localparam int unsigned NPW = 4;
  localparam int unsigned CIW = 9;

  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_IFMAP = 3'b010;
  localparam logic [2:0] OP_WGHT  = 3'b011;
  localparam logic [2:0] OP_CONV  = 3'b100;
  localparam logic [2:0] OP_ACC   = 3'b101;

  typedef struct packed {
    logic [2:0]     op;
    logic [NPW-1:0] pass;
    logic [CIW-1:0] ci;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [CIW-1:0] cfg_ci = '0;
  logic [NPW-1:0] cfg_np = '0;
  logic           cfg_lw = 1'b0;
  logic           ready = 1'b1;
  logic [2:0]     opcode;
  logic [CIW-1:0] conv_info;
  logic           inst_valid;
  logic           busy;
  logic           done;
  logic [NPW-1:0] pass_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   cmd_stall = 1;
  int   acc_stall = 1;
  int   rise_cyc = -100;

  pe_inst_issuer #(.N_PASS_BITWIDTH(NPW), .CONV_INFO_BITWIDTH(CIW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_cfg_conv_info(cfg_ci),
    .i_cfg_npass    (cfg_np),
    .i_cfg_load_wght(cfg_lw),
    .o_opcode       (opcode),
    .o_conv_info    (conv_info),
    .o_inst_valid   (inst_valid),
    .i_inst_ready   (ready),
    .o_busy         (busy),
    .o_done         (done),
    .o_pass_cnt     (pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: the full command list of one program
  task automatic push_prog(input logic [CIW-1:0] ci, input int np, input bit lw);
    int eff;
    eff = (np == 0) ? 1 : np;
    exp_q.push_back({OP_SET, NPW'(0), ci});
    if (lw) exp_q.push_back({OP_WGHT, NPW'(0), ci});
    for (int p = 0; p < eff; p++) begin
      exp_q.push_back({OP_IFMAP, NPW'(p), ci});
      exp_q.push_back({OP_CONV, NPW'(p), ci});
    end
    exp_q.push_back({OP_ACC, NPW'(eff - 1), ci});
  endtask

  // PE model: ready high while idle, low for a stall period after each accept
  initial begin
    int   cnt;
    bit   pend;
    bit   after_acc;
    logic [2:0] pend_op;
    cnt = 0; pend = 0; after_acc = 0; pend_op = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ready = 1'b1; cnt = 0; pend = 0; after_acc = 0;
      end else begin
        if (pend) begin
          ready     = 1'b0;
          after_acc = (pend_op == OP_ACC);
          cnt       = after_acc ? acc_stall : cmd_stall;
          pend      = 0;
        end else if (!ready) begin
          cnt--;
          if (cnt <= 0) begin
            ready = 1'b1;
            if (after_acc) rise_cyc = cyc;
            after_acc = 0;
          end
        end
        if (inst_valid && ready) begin
          pend    = 1;
          pend_op = opcode;
        end
      end
    end
  end

  // Monitor: checks each handshake against the scoreboard and valid/opcode stability
  initial begin
    bit         prev_valid;
    bit         prev_hs;
    logic [2:0] prev_op;
    exp_t       e;
    prev_valid = 0; prev_hs = 0; prev_op = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        prev_valid = 0; prev_hs = 0;
      end else begin
        if (prev_hs) chk("valid_drop_after_hs", 32'(inst_valid), 32'd0);
        else if (prev_valid) begin
          chk("valid_hold", 32'(inst_valid), 32'd1);
          chk("opcode_hold", 32'(opcode), 32'(prev_op));
        end
        if (inst_valid && ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_hs: got opcode %0h, expected no command (t=%0t)", opcode, $time);
          end else begin
            e = exp_q.pop_front();
            chk("hs_opcode", 32'(opcode), 32'(e.op));
            chk("hs_pass_cnt", 32'(pass_cnt), 32'(e.pass));
            chk("hs_conv_info", 32'(conv_info), 32'(e.ci));
          end
        end
        prev_hs    = inst_valid && ready;
        prev_valid = inst_valid;
        prev_op    = opcode;
      end
    end
  end

  // One complete program, optionally with start/cfg noise while it runs
  task automatic run_prog(input logic [CIW-1:0] ci, input int np, input bit lw,
                          input int st, input int acc_st, input bit noise);
    bit got_done;
    cmd_stall = st;
    acc_stall = acc_st;
    rise_cyc  = -100;
    @(negedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    cfg_ci = ci; cfg_np = NPW'(np); cfg_lw = lw; start = 1'b1;
    push_prog(ci, np, lw);
    @(negedge clk); #1;
    start  = 1'b0;
    cfg_ci = CIW'($urandom); cfg_np = NPW'($urandom); cfg_lw = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("conv_info_captured", 32'(conv_info), 32'(ci));
    got_done = 0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(negedge clk); #1;
      chk("conv_info_hold", 32'(conv_info), 32'(ci));
      if (done) begin
        got_done = 1;
        chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        chk("busy_in_done_cycle", 32'(busy), 32'd1);
        chk("done_after_ready_rise", 32'(cyc - rise_cyc), 32'd1);
      end else begin
        chk("busy_during_prog", 32'(busy), 32'd1);
        if (noise) begin
          start  = 1'($urandom);
          cfg_ci = CIW'($urandom);
        end
      end
    end
    if (!got_done) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done within 3000 cycles, expected a done pulse");
    end
    // A start in the done cycle must be ignored
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("start_in_fin_ignored", 32'(busy), 32'd0);
    chk("conv_info_kept_after", 32'(conv_info), 32'(ci));
  endtask

  // Asynchronous reset while CONV is pending
  task automatic reset_mid_conv();
    bit found;
    cmd_stall = 5;
    acc_stall = 2;
    @(negedge clk); #1;
    cfg_ci = 9'h1A5; cfg_np = 4'd3; cfg_lw = 1'b1; start = 1'b1;
    push_prog(9'h1A5, 3, 1'b1);
    @(negedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk); #1;
      if (inst_valid && opcode == OP_CONV) found = 1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL conv_wait_timeout: got no CONV issue within 500 cycles, expected one");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("rst_conv_info", 32'(conv_info), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_opcode", 32'(opcode), 32'd0);
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("reset_conv_info", 32'(conv_info), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_prog(9'b011_010_011, 2, 1'b1, 1, 1, 1'b0);
    run_prog(9'b011_010_011, 2, 1'b1, 5, 5, 1'b0);
    run_prog(CIW'($urandom), 0, 1'b0, 1, 2, 1'b0);
    run_prog(9'b101_001_110, 3, 1'b1, 2, 3, 1'b1);
    reset_mid_conv();
    run_prog(9'b001_001_001, 1, 1'b0, 1, 1, 1'b0);
    run_prog(9'b111_000_111, 2, 1'b1, 1, 20, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_prog(CIW'($urandom), int'($urandom_range(0, 5)), 1'($urandom),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_inst_issuer.md
Name: pe_inst_issuer

Overview:
- Instruction initiator ("TOP CTRL" side) that drives one PE controller's instruction port.
- On a start pulse it captures a layer configuration and issues a fixed command program, one command per valid/ready handshake: SET, optional LOAD_WGHT, N × (LOAD_IFMAP, CONV), then ACC.
- It then waits for the PE to return to idle and pulses done.
- Sits between the global scheduler and each PE column.

Parameters:
- N_PASS_BITWIDTH, 4, width of the pass-count configuration and pass counter.
- CONV_INFO_BITWIDTH, 9, width of the conv_info word {P[2:0], Q[2:0], S[2:0]}.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_cfg_conv_info  input  CONV_INFO_BITWIDTH  {P,Q,S} for the layer.
- i_cfg_npass  input  N_PASS_BITWIDTH  number of LOAD_IFMAP/CONV pairs.
- i_cfg_load_wght  input  1  1 = issue LOAD_WGHT after SET.
- o_opcode  output  3  command: NOP=000, SET=001, LOAD_IFMAP=010, LOAD_WGHT=011, CONV=100, ACC=101.
- o_conv_info  output  CONV_INFO_BITWIDTH  registered copy of i_cfg_conv_info.
- o_inst_valid  output  1  command valid.
- i_inst_ready  input  1  PE accepts command (PE high only while idle).
- o_busy  output  1  high from the cycle after start acceptance until the done cycle inclusive.
- o_done  output  1  one-cycle pulse at program completion.
- o_pass_cnt  output  N_PASS_BITWIDTH  index of the current LOAD_IFMAP/CONV pass.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=IDLE; all outputs 0: o_opcode=000, o_conv_info=0, o_inst_valid=0, o_busy=0, o_done=0, o_pass_cnt=0.
  - Takes effect immediately, including mid-program; o_inst_valid drops without waiting for handshake.
- Handshake:
  - hs = o_inst_valid & i_inst_ready.
  - o_opcode is registered and held stable while o_inst_valid=1 and not hs.
  - o_inst_valid is deasserted the cycle after hs.
  - Exactly one hs per issued command.
- o_conv_info is loaded when start is accepted and held constant until the next accepted start. The PE samples it several cycles after the SET handshake, so it must not change mid-program.
- States and transitions:
  - IDLE: i_start=1 → capture cfg; o_pass_cnt=0; o_busy=1; → ISS_SET.
  - ISS_SET: opcode SET, valid=1. On hs → ISS_WGHT if load_wght=1, else ISS_IFMAP.
  - ISS_WGHT: opcode LOAD_WGHT. On hs → ISS_IFMAP.
  - ISS_IFMAP: opcode LOAD_IFMAP. On hs → ISS_CONV.
  - ISS_CONV: opcode CONV. On hs, if o_pass_cnt == npass_eff-1 → ISS_ACC; else o_pass_cnt+1 and → ISS_IFMAP.
  - ISS_ACC: opcode ACC. On hs → DRAIN_LO.
  - DRAIN_LO: valid=0; wait for i_inst_ready=0 (PE has left idle).
  - DRAIN_HI: wait for i_inst_ready=1 (PE back to idle).
  - FIN: o_done=1 for one cycle; → IDLE. o_busy falls with IDLE.
- npass_eff = (captured npass == 0) ? 1 : captured npass. A zero count still runs one pass.
- Commands: each command is issued only after the prior command's hs. The PE's ready naturally stalls each issue until it has completed the previous command; no extra timers.
- i_start while not IDLE: ignored, no error. i_start in the FIN cycle: ignored; it is accepted only in IDLE.
- i_inst_ready high with o_inst_valid low: no effect.
- Command count per program: 1 + load_wght + 2·npass_eff + 1.
- ready/valid with hs on the same cycle as the state entry is allowed. Minimum of 1 cycle per issue state.

Test Plan:
1. Reset, then start with conv_info=9'b011_010_011 (P=3,Q=2,S=3), npass=2, load_wght=1; PE model always ready → opcodes SET, LOAD_WGHT, LOAD_IFMAP, CONV, LOAD_IFMAP, CONV, ACC (7 handshakes); o_pass_cnt 0 then 1; one o_done pulse; o_conv_info constant throughout.
2. Same run with the PE model holding ready low for 5 cycles after each hs → o_opcode and o_inst_valid stable during the stall; same 7-command order; no duplicate handshakes.
3. load_wght=0, npass=0 → exactly SET, LOAD_IFMAP, CONV, ACC (npass treated as 1); done pulse.
4. Change i_cfg_conv_info and pulse i_start repeatedly mid-program → ignored; o_conv_info keeps the first value; program completes normally.
5. Assert i_rst_n=0 during ISS_CONV with valid high → o_inst_valid, o_busy, o_opcode drop to 0 asynchronously; after release, a new start runs from SET.
6. After the ACC hs, hold ready low 20 cycles, then high → o_done asserts exactly 1 cycle after ready returns high (DRAIN_HI→FIN), never before.
